// File: rtl/axi4_pkg.sv
// Shared AXI4 codes, FSM state types and the beat-size helper used by the
// RAM responder and the master BFM.
package axi4_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  typedef enum logic       {R_IDLE, R_DATA}         r_state_e;

  // AxSIZE encoding for an n-byte beat (log2(n)); n must be a power of 2.
  function automatic logic [2:0] size_of(input int unsigned n);
    logic [2:0] s;
    s = 3'd0;
    for (int unsigned k = 0; k < 8; k++) begin
      if (n == (32'd1 << k)) s = 3'(k);
    end
    return s;
  endfunction

endpackage

// File: rtl/axi4_ram_slave_if.sv
// AXI4 five-channel bundle between a master and the RAM responder.
interface axi4_ram_slave_if #(
  parameter int unsigned N = 4,
  parameter int unsigned I = 1
);
  logic [I-1:0]   awid;
  logic [31:0]    awaddr;
  logic [7:0]     awlen;
  logic [2:0]     awsize;
  logic [1:0]     awburst;
  logic           awvalid;
  logic           awready;

  logic [8*N-1:0] wdata;
  logic [N-1:0]   wstrb;
  logic           wlast;
  logic           wvalid;
  logic           wready;

  logic [I-1:0]   bid;
  logic [1:0]     bresp;
  logic           bvalid;
  logic           bready;

  logic [I-1:0]   arid;
  logic [31:0]    araddr;
  logic [7:0]     arlen;
  logic [2:0]     arsize;
  logic [1:0]     arburst;
  logic           arvalid;
  logic           arready;

  logic [I-1:0]   rid;
  logic [8*N-1:0] rdata;
  logic [1:0]     rresp;
  logic           rlast;
  logic           rvalid;
  logic           rready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awvalid, input awready,
    output wdata, wstrb, wlast, wvalid, input wready,
    input  bid, bresp, bvalid, output bready,
    output arid, araddr, arlen, arsize, arburst, arvalid, input arready,
    input  rid, rdata, rresp, rlast, rvalid, output rready
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awvalid, output awready,
    input  wdata, wstrb, wlast, wvalid, output wready,
    output bid, bresp, bvalid, input bready,
    input  arid, araddr, arlen, arsize, arburst, arvalid, output arready,
    output rid, rdata, rresp, rlast, rvalid, input rready
  );
endinterface

// File: rtl/axi4_ram_core.sv
// Byte-enabled RAM: one clocked write port, one asynchronous read port.
module axi4_ram_core #(
  parameter int unsigned N          = 4,
  parameter int unsigned DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] widx,
  input  logic [8*N-1:0]        wdata,
  input  logic [N-1:0]          wstrb,
  input  logic [DEPTH_LOG2-1:0] ridx,
  output logic [8*N-1:0]        rdata_c
);
  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

  logic [8*N-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < int'(N); b++) begin
        if (wstrb[b]) mem[widx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  // Read sees pre-edge contents, so a same-edge write is not forwarded.
  assign rdata_c = mem[ridx];
endmodule

// File: rtl/axi4_ram_slave.sv
// AXI4 RAM responder: one write burst and one read burst in flight, each
// path run by its own FSM over a shared RAM core.
module axi4_ram_slave
  import axi4_pkg::*;
#(
  parameter int unsigned N          = 4,
  parameter int unsigned I          = 1,
  parameter int unsigned DEPTH_LOG2 = 10
) (
  input  logic             aclk,
  input  logic             aresetn,
  axi4_ram_slave_if.slave  bus
);
  localparam int unsigned SZ = $clog2(N);
  localparam int unsigned AW = DEPTH_LOG2 + SZ;
  localparam int unsigned DW = 8 * N;

  typedef logic [DEPTH_LOG2-1:0] idx_t;

  function automatic logic burst_err(input logic [31:0] addr, input logic [2:0] size,
                                     input logic [1:0] burst);
    return (size != size_of(N)) || burst[1] || ((addr >> AW) != 32'd0);
  endfunction

  function automatic idx_t addr_idx(input logic [31:0] addr);
    return idx_t'(addr >> SZ);
  endfunction

  // Write path state and registered outputs
  w_state_e         w_state, w_state_nx;
  idx_t             w_idx, w_idx_nx;
  logic [7:0]       w_len, w_len_nx, w_cnt, w_cnt_nx;
  logic             w_fixed, w_fixed_nx, w_berr, w_berr_nx, w_perr, w_perr_nx;
  logic             awready, awready_nx, wready, wready_nx, bvalid, bvalid_nx;
  logic [I-1:0]     bid, bid_nx;
  logic [1:0]       bresp, bresp_nx;

  // Read path state and registered outputs
  r_state_e         r_state, r_state_nx;
  idx_t             r_idx, r_idx_nx;
  logic [7:0]       r_len, r_len_nx, r_cnt, r_cnt_nx;
  logic             r_fixed, r_fixed_nx, r_err, r_err_nx;
  logic             arready, arready_nx, rvalid, rvalid_nx, rlast, rlast_nx;
  logic [I-1:0]     rid, rid_nx;
  logic [DW-1:0]    rdata, rdata_nx;
  logic [1:0]       rresp, rresp_nx;

  logic             mem_we_c;
  idx_t             mem_ridx_c, r_step_c;
  logic [DW-1:0]    mem_rdata_c;
  logic             w_final_c, w_lastbad_c, ar_err_c;

  assign w_final_c   = (w_cnt == w_len);
  assign w_lastbad_c = (bus.wlast != w_final_c);
  assign ar_err_c    = burst_err(bus.araddr, bus.arsize, bus.arburst);
  assign r_step_c    = r_fixed ? r_idx : r_idx + idx_t'(1);
  assign mem_ridx_c  = (r_state == R_IDLE) ? addr_idx(bus.araddr) : r_step_c;

  axi4_ram_core #(.N(N), .DEPTH_LOG2(DEPTH_LOG2)) u_core (
    .clk    (aclk),
    .we     (mem_we_c),
    .widx   (w_idx),
    .wdata  (bus.wdata),
    .wstrb  (bus.wstrb),
    .ridx   (mem_ridx_c),
    .rdata_c(mem_rdata_c)
  );

  // Write FSM next state; WLAST only grades the burst, the count terminates it.
  always_comb begin
    w_state_nx = w_state;  w_idx_nx   = w_idx;    w_len_nx  = w_len;
    w_cnt_nx   = w_cnt;    w_fixed_nx = w_fixed;  w_berr_nx = w_berr;
    w_perr_nx  = w_perr;   awready_nx = awready;  wready_nx = wready;
    bvalid_nx  = bvalid;   bid_nx     = bid;      bresp_nx  = bresp;
    mem_we_c   = 1'b0;
    case (w_state)
      W_IDLE: begin
        awready_nx = 1'b1;
        if (awready && bus.awvalid) begin
          w_idx_nx   = addr_idx(bus.awaddr);
          w_len_nx   = bus.awlen;
          w_cnt_nx   = 8'd0;
          w_fixed_nx = (bus.awburst == BURST_FIXED);
          w_berr_nx  = burst_err(bus.awaddr, bus.awsize, bus.awburst);
          w_perr_nx  = 1'b0;
          bid_nx     = bus.awid;
          awready_nx = 1'b0;
          wready_nx  = 1'b1;
          w_state_nx = W_DATA;
        end
      end
      W_DATA: begin
        if (wready && bus.wvalid) begin
          mem_we_c = !w_berr;
          if (w_lastbad_c) w_perr_nx = 1'b1;
          if (w_final_c) begin
            bresp_nx   = (w_berr || w_perr || w_lastbad_c) ? RESP_SLVERR : RESP_OKAY;
            bvalid_nx  = 1'b1;
            wready_nx  = 1'b0;
            w_state_nx = W_RESP;
          end else begin
            w_cnt_nx = w_cnt + 8'd1;
            if (!w_fixed) w_idx_nx = w_idx + idx_t'(1);
          end
        end
      end
      W_RESP: begin
        if (bvalid && bus.bready) begin
          bvalid_nx  = 1'b0;
          awready_nx = 1'b1;
          w_state_nx = W_IDLE;
        end
      end
      default: begin
        awready_nx = 1'b0;
        wready_nx  = 1'b0;
        bvalid_nx  = 1'b0;
        w_state_nx = W_IDLE;
      end
    endcase
  end

  // Read FSM next state; the next beat loads on the same edge as a handshake.
  always_comb begin
    r_state_nx = r_state;  r_idx_nx   = r_idx;    r_len_nx = r_len;
    r_cnt_nx   = r_cnt;    r_fixed_nx = r_fixed;  r_err_nx = r_err;
    arready_nx = arready;  rvalid_nx  = rvalid;   rlast_nx = rlast;
    rid_nx     = rid;      rdata_nx   = rdata;    rresp_nx = rresp;
    case (r_state)
      R_IDLE: begin
        arready_nx = 1'b1;
        if (arready && bus.arvalid) begin
          r_idx_nx   = addr_idx(bus.araddr);
          r_len_nx   = bus.arlen;
          r_cnt_nx   = 8'd0;
          r_fixed_nx = (bus.arburst == BURST_FIXED);
          r_err_nx   = ar_err_c;
          rid_nx     = bus.arid;
          rdata_nx   = ar_err_c ? '0 : mem_rdata_c;
          rresp_nx   = ar_err_c ? RESP_SLVERR : RESP_OKAY;
          rlast_nx   = (bus.arlen == 8'd0);
          rvalid_nx  = 1'b1;
          arready_nx = 1'b0;
          r_state_nx = R_DATA;
        end
      end
      R_DATA: begin
        if (rvalid && bus.rready) begin
          if (rlast) begin
            rvalid_nx  = 1'b0;
            arready_nx = 1'b1;
            r_state_nx = R_IDLE;
          end else begin
            r_cnt_nx = r_cnt + 8'd1;
            r_idx_nx = r_step_c;
            rdata_nx = r_err ? '0 : mem_rdata_c;
            rlast_nx = (8'(r_cnt + 8'd1) == r_len);
          end
        end
      end
      default: r_state_nx = R_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      w_state <= W_IDLE;  w_idx   <= '0;    w_len  <= '0;    w_cnt  <= '0;
      w_fixed <= 1'b0;    w_berr  <= 1'b0;  w_perr <= 1'b0;
      awready <= 1'b0;    wready  <= 1'b0;  bvalid <= 1'b0;
      bid     <= '0;      bresp   <= '0;
    end else begin
      w_state <= w_state_nx;  w_idx  <= w_idx_nx;   w_len  <= w_len_nx;
      w_cnt   <= w_cnt_nx;    w_fixed <= w_fixed_nx; w_berr <= w_berr_nx;
      w_perr  <= w_perr_nx;   awready <= awready_nx; wready <= wready_nx;
      bvalid  <= bvalid_nx;   bid    <= bid_nx;     bresp  <= bresp_nx;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state <= R_IDLE;  r_idx  <= '0;    r_len  <= '0;    r_cnt <= '0;
      r_fixed <= 1'b0;    r_err  <= 1'b0;  arready <= 1'b0;
      rvalid  <= 1'b0;    rlast  <= 1'b0;  rid    <= '0;
      rdata   <= '0;      rresp  <= '0;
    end else begin
      r_state <= r_state_nx;  r_idx  <= r_idx_nx;   r_len   <= r_len_nx;
      r_cnt   <= r_cnt_nx;    r_fixed <= r_fixed_nx; r_err  <= r_err_nx;
      arready <= arready_nx;  rvalid <= rvalid_nx;  rlast   <= rlast_nx;
      rid     <= rid_nx;      rdata  <= rdata_nx;   rresp   <= rresp_nx;
    end
  end

  assign bus.awready = awready;
  assign bus.wready  = wready;
  assign bus.bvalid  = bvalid;
  assign bus.bid     = bid;
  assign bus.bresp   = bresp;
  assign bus.arready = arready;
  assign bus.rvalid  = rvalid;
  assign bus.rlast   = rlast;
  assign bus.rid     = rid;
  assign bus.rdata   = rdata;
  assign bus.rresp   = rresp;
endmodule

// File: tb/tb_axi4_ram_slave.sv
// Directed bench for axi4_ram_slave: B and R beats are predicted from a
// reference RAM model into queues and checked as the DUT produces them.
module tb_axi4_ram_slave;
  import axi4_pkg::*;

  localparam int unsigned N  = 4;
  localparam int unsigned I  = 1;
  localparam int unsigned DL = 10;
  localparam int          TMO = 50;

  logic aclk    = 1'b0;
  logic aresetn = 1'b1;
  always #5 aclk = ~aclk;

  axi4_ram_slave_if #(.N(N), .I(I)) bus ();

  axi4_ram_slave #(.N(N), .I(I), .DEPTH_LOG2(DL)) dut (
    .aclk   (aclk),
    .aresetn(aresetn),
    .bus    (bus)
  );

  int errors = 0;
  int checks = 0;

  logic [31:0] model [1 << DL];
  logic [31:0] wbuf  [16];
  logic [3:0]  wstrb_v;
  bit          rpat  [$];
  logic [2:0]  bq    [$];   // {bid, bresp}
  logic [36:0] rq    [$];   // {rvalid, rid, rdata, rresp, rlast}

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  function automatic logic berr(input logic [31:0] addr, input logic [2:0] size,
                                input logic [1:0] burst);
    return (size != 3'd2) || burst[1] || ((addr >> 12) != 32'd0);
  endfunction

  function automatic logic [36:0] r_obs();
    return {bus.rvalid, bus.rid, bus.rdata, bus.rresp, bus.rlast};
  endfunction

  task automatic do_write(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                          input logic [1:0] burst, input logic id, input int bad_last,
                          input int bhold);
    logic       err;
    logic [9:0] idx;
    logic [2:0] exp_b;
    int         n;
    err = berr(addr, size, burst);
    idx = addr[11:2];
    bq.push_back({id, (err || bad_last >= 0) ? RESP_SLVERR : RESP_OKAY});
    if (!err) begin
      for (int b = 0; b <= int'(len); b++) begin
        for (int k = 0; k < 4; k++) if (wstrb_v[k]) model[idx][8*k +: 8] = wbuf[b][8*k +: 8];
        if (burst == BURST_INCR) idx = idx + 10'd1;
      end
    end
    bus.awid = id; bus.awaddr = addr; bus.awlen = len; bus.awsize = size;
    bus.awburst = burst; bus.awvalid = 1'b1;
    n = 0;
    while (bus.awready !== 1'b1 && n < TMO) begin tick(); n++; end
    chk("aw_wait", 64'(n < TMO), 64'd1);
    tick();
    bus.awvalid = 1'b0;
    for (int b = 0; b <= int'(len); b++) begin
      bus.wdata = wbuf[b]; bus.wstrb = wstrb_v;
      bus.wlast = (b == int'(len)) ^ (b == bad_last);
      bus.wvalid = 1'b1;
      n = 0;
      while (bus.wready !== 1'b1 && n < TMO) begin tick(); n++; end
      if (n >= TMO) chk("w_wait", 64'(n), 64'd0);
      tick();
    end
    bus.wvalid = 1'b0; bus.wlast = 1'b0;
    bus.bready = 1'b0;
    for (int k = 0; k < bhold; k++) begin
      tick();
      chk("b_hold_bvalid", 64'(bus.bvalid), 64'd1);
      chk("b_hold_awready", 64'(bus.awready), 64'd0);
    end
    bus.bready = 1'b1;
    n = 0;
    while (bus.bvalid !== 1'b1 && n < TMO) begin tick(); n++; end
    exp_b = bq.pop_front();
    chk("bresp", 64'({bus.bvalid, bus.bid, bus.bresp}), 64'({1'b1, exp_b}));
    tick();
    bus.bready = 1'b0;
    chk("b_drop", 64'(bus.bvalid), 64'd0);
    chk("aw_ready_again", 64'(bus.awready), 64'd1);
  endtask

  task automatic ar_issue(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                          input logic [1:0] burst, input logic id);
    int n;
    bus.arid = id; bus.araddr = addr; bus.arlen = len; bus.arsize = size;
    bus.arburst = burst; bus.arvalid = 1'b1;
    n = 0;
    while (bus.arready !== 1'b1 && n < TMO) begin tick(); n++; end
    chk("ar_wait", 64'(n < TMO), 64'd1);
    tick();
    bus.arvalid = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                         input logic [1:0] burst, input logic id);
    logic        err, stalled;
    logic [9:0]  idx;
    logic [36:0] held, exp_r;
    int          cyc;
    err = berr(addr, size, burst);
    idx = addr[11:2];
    for (int b = 0; b <= int'(len); b++) begin
      rq.push_back({1'b1, id, err ? 32'd0 : model[idx], err ? RESP_SLVERR : RESP_OKAY,
                    b == int'(len)});
      if (burst == BURST_INCR) idx = idx + 10'd1;
    end
    ar_issue(addr, len, size, burst, id);
    stalled = 1'b0; held = '0; cyc = 0;
    while (rq.size() > 0 && cyc < 200) begin
      if (stalled) chk("r_stable", 64'(r_obs()), 64'(held));
      stalled = 1'b0;
      if (bus.rvalid === 1'b1) begin
        bus.rready = (rpat.size() > 0) ? rpat.pop_front() : 1'b1;
        if (bus.rready) begin
          exp_r = rq.pop_front();
          chk("r_beat", 64'(r_obs()), 64'(exp_r));
        end else begin
          stalled = 1'b1;
          held = r_obs();
        end
      end else begin
        bus.rready = 1'b0;
      end
      tick();
      cyc++;
    end
    chk("r_all_beats", 64'(rq.size()), 64'd0);
    rq.delete();
    bus.rready = 1'b0;
    chk("r_no_extra", 64'(bus.rvalid), 64'd0);
    chk("ar_ready_again", 64'(bus.arready), 64'd1);
  endtask

  initial begin
    for (int i = 0; i < (1 << DL); i++) model[i] = 'x;
    bus.awid = '0; bus.awaddr = '0; bus.awlen = '0; bus.awsize = '0; bus.awburst = '0;
    bus.awvalid = 1'b0; bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0; bus.wvalid = 1'b0;
    bus.bready = 1'b0; bus.arid = '0; bus.araddr = '0; bus.arlen = '0; bus.arsize = '0;
    bus.arburst = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;

    // Reset: every output low, readies rise on the first edge after release
    #2 aresetn = 1'b0;
    tick(); tick();
    chk("rst_outputs", 64'({bus.awready, bus.wready, bus.bvalid, bus.bid, bus.bresp,
                            bus.arready, bus.rvalid, bus.rid, bus.rresp, bus.rlast}), 64'd0);
    chk("rst_rdata", 64'(bus.rdata), 64'd0);
    @(negedge aclk);
    aresetn = 1'b1;
    #1;
    chk("pre_edge_awready", 64'(bus.awready), 64'd0);
    tick();
    chk("post_rst_ready", 64'({bus.awready, bus.arready, bus.bvalid, bus.rvalid, bus.wready}),
        64'b11000);

    // INCR burst write then read back
    wbuf[0] = 32'h11111111; wbuf[1] = 32'h22222222; wbuf[2] = 32'h33333333;
    wbuf[3] = 32'h44444444; wstrb_v = 4'hF;
    do_write(32'h10, 8'd3, 3'd2, BURST_INCR, 1'b1, -1, 0);
    do_read(32'h10, 8'd3, 3'd2, BURST_INCR, 1'b0);

    // Partial strobe over a zeroed word
    wbuf[0] = 32'h0; wstrb_v = 4'hF;
    do_write(32'h40, 8'd0, 3'd2, BURST_INCR, 1'b0, -1, 0);
    wbuf[0] = 32'hAABBCCDD; wstrb_v = 4'b0101;
    do_write(32'h40, 8'd0, 3'd2, BURST_INCR, 1'b1, -1, 0);
    do_read(32'h40, 8'd0, 3'd2, BURST_INCR, 1'b1);

    // Read backpressure 1,0,0,1 and write response held off for 5 cycles
    rpat = '{1'b1, 1'b0, 1'b0, 1'b1};
    do_read(32'h14, 8'd2, 3'd2, BURST_INCR, 1'b1);
    wbuf[0] = 32'hCAFEF00D; wbuf[1] = 32'h0BADBEEF; wstrb_v = 4'hF;
    do_write(32'h80, 8'd1, 3'd2, BURST_INCR, 1'b1, -1, 5);
    do_read(32'h80, 8'd1, 3'd2, BURST_INCR, 1'b0);

    // FIXED burst keeps one word: the last beat wins
    wbuf[0] = 32'h12345678; wbuf[1] = 32'h9ABCDEF0;
    do_write(32'h100, 8'd1, 3'd2, BURST_FIXED, 1'b0, -1, 0);
    do_read(32'h100, 8'd1, 3'd2, BURST_FIXED, 1'b1);

    // Error bursts: bad size, out-of-range address, WRAP read, early WLAST
    wbuf[0] = 32'hDEADBEEF;
    do_write(32'h10, 8'd0, 3'd0, BURST_INCR, 1'b1, -1, 0);
    do_read(32'h10, 8'd0, 3'd2, BURST_INCR, 1'b0);
    do_write(32'h1010, 8'd0, 3'd2, BURST_INCR, 1'b0, -1, 0);
    do_read(32'h10, 8'd1, 3'd2, BURST_WRAP, 1'b1);
    do_read(32'h2000, 8'd0, 3'd2, BURST_INCR, 1'b0);
    wbuf[0] = 32'h1; wbuf[1] = 32'h2; wbuf[2] = 32'h3;
    do_write(32'h200, 8'd2, 3'd2, BURST_INCR, 1'b1, 0, 0);

    // Reset during beat 2 of an 8-beat read
    ar_issue(32'h10, 8'd7, 3'd2, BURST_INCR, 1'b1);
    chk("mid_rd_beat1", 64'(bus.rvalid), 64'd1);
    bus.rready = 1'b1;
    tick();
    chk("mid_rd_beat2", 64'(bus.rvalid), 64'd1);
    bus.rready = 1'b0;
    #2 aresetn = 1'b0;
    #1;
    chk("abort_rvalid", 64'({bus.rvalid, bus.arready, bus.awready}), 64'd0);
    @(negedge aclk);
    aresetn = 1'b1;
    tick();
    chk("abort_recover", 64'({bus.arready, bus.awready, bus.rvalid}), 64'b110);
    do_read(32'h10, 8'd3, 3'd2, BURST_INCR, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/axi4_ram_slave.md
Name: axi4_ram_slave

Overview:
- Synthesizable AXI4 memory responder: the completer end of the AXI4 channels that the team's master BFM drives.
- Accepts AW/W bursts and stores them into an internal RAM; serves AR bursts back on R.
- Used as the default DUT-side target in BFM benches and as a scratch RAM in subsystem sims.
- One write burst and one read burst outstanding at a time; the read and write paths are independent.

Parameters:
N, 4, bytes per data beat (power of 2, 1..64)
I, 1, ID width
DEPTH_LOG2, 10, log2 of RAM depth in N-byte words

Ports:
ACLK  in  1  clock, all logic on rising edge
ARESETn  in  1  asynchronous active-low reset
AWID/AWADDR/AWLEN/AWSIZE/AWBURST  in  I/32/8/3/2  write address payload
AWVALID in 1 / AWREADY out 1  write address handshake
WDATA/WSTRB/WLAST  in  8*N/N/1  write data payload
WVALID in 1 / WREADY out 1  write data handshake
BID/BRESP  out  I/2  write response payload
BVALID out 1 / BREADY in 1  write response handshake
ARID/ARADDR/ARLEN/ARSIZE/ARBURST  in  I/32/8/3/2  read address payload
ARVALID in 1 / ARREADY out 1  read address handshake
RID/RDATA/RRESP/RLAST  out  I/8*N/2/1  read data payload
RVALID out 1 / RREADY in 1  read data handshake

Behaviour:
- Reset (async assert, sync deassert): every output 0, including payloads. Write FSM and read FSM go to IDLE. RAM contents are not cleared.
- AWREADY and ARREADY rise on the first ACLK edge after ARESETn deasserts.
- Reset asserted mid-burst: abort immediately to IDLE; no B or R beat is issued for the aborted burst.
- Word index = addr[DEPTH_LOG2+log2(N)-1 : log2(N)]. Low log2(N) address bits are ignored; there is no unaligned support.
- Burst error: flagged at the address handshake if any of the following holds:
  - AxSIZE != log2(N)
  - AxBURST == WRAP (2'b10) or reserved (2'b11)
  - any address bit at or above DEPTH_LOG2+log2(N) is set
- Address stepping: FIXED holds the index; INCR adds 1 per beat, modulo 2^DEPTH_LOG2.
- Write FSM, W_IDLE -> W_DATA -> W_RESP:
  - W_IDLE: AWREADY=1. On AW handshake, latch ID/index/len/error, go to W_DATA, AWREADY=0.
  - W_DATA: WREADY=1. Each W handshake writes the bytes selected by WSTRB (suppressed if error). The beat counter runs to AWLEN+1; the beat with count==AWLEN moves to W_RESP.
  - WLAST is not used for termination. WLAST on any beat other than the final one, or WLAST=0 on the final beat, sets the protocol error flag.
  - W_RESP: BVALID=1, BID=latched ID, BRESP=SLVERR (2'b10) if any error flag is set, else OKAY. Held stable until BREADY. On handshake: BVALID=0, go to W_IDLE, AWREADY=1 on the same edge.
- Read FSM, R_IDLE -> R_DATA:
  - R_IDLE: ARREADY=1. On AR handshake, latch ID/len/error, load RDATA=mem[index], assert RVALID on the next edge (1-cycle latency), RLAST = (ARLEN==0).
  - R_DATA: payload held stable while RVALID && !RREADY.
  - On handshake of a non-last beat, load the next beat on the same edge, so back-to-back beats run at one per cycle when RREADY=1.
  - On handshake of the last beat: RVALID=0, go to R_IDLE.
  - Error burst: all ARLEN+1 beats are returned with RDATA=0 and RRESP=SLVERR.
- Simultaneous read load and write to the same word on one edge: the read returns the old (pre-write) data.
- Write and read FSMs never stall each other. A W beat presented before the AW handshake is not accepted (WREADY=0 in W_IDLE).

Decomposition:
- axi4_pkg holds:
  - resp codes: OKAY 2'b00, EXOKAY 2'b01, SLVERR 2'b10, DECERR 2'b11
  - burst codes: FIXED 2'b00, INCR 2'b01, WRAP 2'b10
  - function size_of(N) returning log2(N) as 3 bits, shared with the master's reset AxSIZE default
- One sub-module, axi4_ram_core #(N, DEPTH_LOG2):
  - one write port with byte enables
  - one asynchronous read port
  - read and write indexes independent

Test Plan:
- Reset with outputs probed -> all 0. AWREADY=ARREADY=1 one edge after ARESETn rises. BVALID=RVALID=0.
- INCR write, N=4, addr 0x10, AWLEN=3, data 0x11111111..0x44444444, WSTRB=4'hF -> BRESP=OKAY. INCR read of the same burst returns the 4 words in order, RLAST only on beat 4, RRESP=OKAY.
- Partial strobe: write 0xAABBCCDD with WSTRB=4'b0101 over 0x00000000 -> readback 0x00BB00DD.
- Backpressure: RREADY toggling 1,0,0,1 during an ARLEN=2 read -> RDATA/RID/RLAST stable while stalled; exactly 3 beats delivered. BREADY held low 5 cycles -> BVALID stays 1, AWREADY stays 0.
- Errors: AWSIZE=0 with N=4 -> RAM unchanged, BRESP=SLVERR. ARBURST=WRAP, ARLEN=1 -> 2 beats with RDATA=0 and RRESP=SLVERR. WLAST early on beat 1 of 3 -> BRESP=SLVERR after 3 beats.
- Reset asserted during beat 2 of an ARLEN=7 read -> RVALID=0 immediately; after release ARREADY=1 and earlier RAM data is still readable.
